keypad_scanner: RTL and testbench

- Input-side counterpart to the multiplexed seven-segment display driver.
- The display driver rotates an active-low select across digits to write; this block rotates an active-low column drive across a 4x4 matrix keypad and reads the row lines back.
- It debounces each press and emits one key-code pulse per press.
- The outputs replace raw push-button inputs, e.g. to step the display clock selection or to load digits.

---
 rtl/keypad_pkg.sv | 31 +++
 rtl/keypad_scanner_if.sv | 23 ++
 rtl/scan_tick_gen.sv | 23 ++
 rtl/keypad_scanner.sv | 136 +++++++++++++
 tb/tb_keypad_scanner.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/keypad_pkg.sv
// Shared types and constants for the matrix keypad scanner.
// State encoding, column drive patterns and row-sense helpers.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    localparam logic [3:0] COL_IDLE   = 4'b1111;
    localparam logic [3:0] COL0_DRIVE = 4'b1110;
    localparam logic [3:0] ROW_IDLE   = 4'b1111;

    localparam int ROW_W = 2;
    localparam int COL_W = 2;

    // Number of active-low rows in a sample.
    function automatic logic [2:0] rows_low(input logic [3:0] r_n);
        return {2'b00, ~r_n[0]} + {2'b00, ~r_n[1]} + {2'b00, ~r_n[2]} + {2'b00, ~r_n[3]};
    endfunction

    function automatic logic [ROW_W-1:0] row_index(input logic [3:0] r_n);
        if (!r_n[0])      return 2'd0;
        else if (!r_n[1]) return 2'd1;
        else if (!r_n[2]) return 2'd2;
        else              return 2'd3;
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad-side and key-event signals of the scanner, grouped for port binding.
// key_valid is a one-cycle strobe qualifying key_code; there is no ready, so the consumer must take it on that cycle.
interface keypad_scanner_if;
    import keypad_pkg::*;

    logic [3:0] row_n;
    logic [3:0] col_n;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;
    state_t     state;

    modport master (
        input  row_n,
        output col_n, key_code, key_valid, key_held, state
    );

    modport slave (
        output row_n,
        input  col_n, key_code, key_valid, key_held, state
    );

endinterface

// File: rtl/scan_tick_gen.sv
// Free-running divider emitting a one-clock tick every SCAN_DIV clocks.
// Wraps independently of any consumer state, so ticks are strictly periodic.
module scan_tick_gen #(
    parameter int SCAN_DIV = 50000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);
    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)            cnt <= '0;
        else if (cnt == LAST) cnt <= '0;
        else                  cnt <= cnt + 1'b1;
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: rotates an active-low column drive, debounces the
// row response and emits one key_code/key_valid event per accepted press.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV         = 50000,
    parameter int DEBOUNCE_SAMPLES = 8
) (
    input  logic              clk,
    input  logic              reset,
    keypad_scanner_if.master  kp
);
    localparam int CNT_W = $clog2(DEBOUNCE_SAMPLES + 1);
    localparam logic [CNT_W-1:0] DS_C  = CNT_W'(DEBOUNCE_SAMPLES);
    localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

    logic             tick;
    logic [3:0]       row_s1, row_s2;
    logic [2:0]       n_low;
    state_t           state, state_d;
    logic [3:0]       col_n_q, col_n_d;
    logic [COL_W-1:0] col_idx, col_idx_d;
    logic [3:0]       pattern, pattern_d;
    logic [CNT_W-1:0] cnt, cnt_d, cnt_inc;
    logic [3:0]       key_code, key_code_d;
    logic             key_valid, key_valid_d;
    logic             key_held, key_held_d;

    scan_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    // Rows are asynchronous to clk; nothing downstream sees row_n directly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_s1 <= ROW_IDLE;
            row_s2 <= ROW_IDLE;
        end else begin
            row_s1 <= kp.row_n;
            row_s2 <= row_s1;
        end
    end

    assign n_low   = rows_low(row_s2);
    assign cnt_inc = cnt + ONE_C;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= SCAN;
            col_n_q   <= COL0_DRIVE;
            col_idx   <= '0;
            pattern   <= ROW_IDLE;
            cnt       <= '0;
            key_code  <= '0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            state     <= state_d;
            col_n_q   <= col_n_d;
            col_idx   <= col_idx_d;
            pattern   <= pattern_d;
            cnt       <= cnt_d;
            key_code  <= key_code_d;
            key_valid <= key_valid_d;
            key_held  <= key_held_d;
        end
    end

    always_comb begin
        state_d     = state;
        col_n_d     = col_n_q;
        col_idx_d   = col_idx;
        pattern_d   = pattern;
        cnt_d       = cnt;
        key_code_d  = key_code;
        key_valid_d = 1'b0;
        key_held_d  = key_held;
        case (state)
            SCAN: begin
                if (tick) begin
                    if (n_low == 3'd0) begin
                        col_n_d   = {col_n_q[2:0], col_n_q[3]};
                        col_idx_d = col_idx + 2'd1;
                    end else begin
                        pattern_d = row_s2;
                        cnt_d     = ONE_C;
                        state_d   = DEBOUNCE;
                    end
                end
            end
            DEBOUNCE: begin
                // Acceptance happens the clock after the final confirming tick.
                if (cnt == DS_C) begin
                    key_code_d  = {row_index(pattern), col_idx};
                    key_valid_d = 1'b1;
                    key_held_d  = 1'b1;
                    state_d     = HELD;
                end else if (tick) begin
                    if (row_s2 == pattern && n_low == 3'd1) cnt_d = cnt_inc;
                    else if (row_s2 == pattern)             cnt_d = ONE_C;
                    else                                    state_d = SCAN;
                end
            end
            HELD: begin
                if (tick && n_low == 3'd0) begin
                    cnt_d   = ONE_C;
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                if (tick) begin
                    if (n_low != 3'd0) begin
                        state_d = HELD;
                    end else if (cnt_inc == DS_C) begin
                        key_held_d = 1'b0;
                        col_n_d    = {col_n_q[2:0], col_n_q[3]};
                        col_idx_d  = col_idx + 2'd1;
                        state_d    = SCAN;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            default: state_d = SCAN;
        endcase
    end

    assign kp.col_n     = col_n_q;
    assign kp.key_code  = key_code;
    assign kp.key_valid = key_valid;
    assign kp.key_held  = key_held;
    assign kp.state     = state;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_SAMPLES=3: a keypad model
// closes row/column contacts, expected key codes are queued and matched on key_valid.
module tb_keypad_scanner;

    typedef struct {
        logic [1:0] row;
        logic [1:0] col;
        logic [3:0] code;
        logic [3:0] col_held;
        logic [3:0] col_after;
    } key_vec_t;

    logic        clk;
    logic        reset;
    logic [15:0] pressed;
    logic [1:0]  ph;
    logic [3:0]  exp_q[$];
    int          checks;
    int          errors;

    keypad_scanner_if kif();

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SAMPLES(3)) dut (
        .clk   (clk),
        .reset (reset),
        .kp    (kif)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent slot-phase model: the divider wraps every 4 clocks from reset.
    always @(posedge clk or posedge reset) begin
        if (reset) ph <= 2'd0;
        else       ph <= ph + 2'd1;
    end

    // Keypad matrix: a pressed key pulls its row low while its column is driven.
    always_comb begin
        logic [3:0] rows;
        rows = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !kif.col_n[c]) rows[r] = 1'b0;
        kif.row_n = rows;
    end

    // ---------------- checking ----------------
    task automatic check(input string nm, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    // Scoreboard: every key_valid must match the oldest expected code.
    always @(negedge clk) begin
        if (!reset && kif.key_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_key_valid: got code %b expected no event at %0t", kif.key_code, $time);
            end else begin
                check("key_code_on_valid", kif.key_code, exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Return 1 time unit after the next slot-end clock edge.
    task automatic next_tick();
        @(negedge clk);
        while (ph != 2'd3) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_held(input logic v, input string nm);
        int n;
        n = 0;
        while (kif.key_held !== v && n < 40) begin
            next_tick();
            n++;
        end
        #12;
        check(nm, {3'b000, kif.key_held}, {3'b000, v});
    endtask

    task automatic goto_col(input logic [3:0] target);
        int n;
        n = 0;
        while (kif.col_n !== target && n < 16) begin
            next_tick();
            n++;
        end
        check("goto_col", kif.col_n, target);
    endtask

    initial begin
        #2_000_000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // ---------------- test ----------------
    initial begin
        key_vec_t   vecs[5];
        logic [3:0] scan_seq[4];

        vecs[0] = '{row: 2'd2, col: 2'd1, code: 4'b1001, col_held: 4'b1101, col_after: 4'b1011};
        vecs[1] = '{row: 2'd0, col: 2'd0, code: 4'b0000, col_held: 4'b1110, col_after: 4'b1101};
        vecs[2] = '{row: 2'd3, col: 2'd3, code: 4'b1111, col_held: 4'b0111, col_after: 4'b1110};
        vecs[3] = '{row: 2'd1, col: 2'd2, code: 4'b0110, col_held: 4'b1011, col_after: 4'b0111};
        vecs[4] = '{row: 2'd0, col: 2'd3, code: 4'b0011, col_held: 4'b0111, col_after: 4'b1110};
        scan_seq = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};

        checks  = 0;
        errors  = 0;
        pressed = '0;
        reset   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_col_n", kif.col_n, 4'b1110);
        check("reset_key_code", kif.key_code, 4'b0000);
        check("reset_key_valid", {3'b000, kif.key_valid}, 4'b0000);
        check("reset_key_held", {3'b000, kif.key_held}, 4'b0000);
        @(negedge clk);
        reset = 1'b0;

        // Idle scanning: column rotates once per slot.
        for (int i = 0; i < 4; i++) begin
            next_tick();
            check("idle_scan_col", kif.col_n, scan_seq[i]);
        end
        check("idle_key_held", {3'b000, kif.key_held}, 4'b0000);

        // Clean presses from the table.
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(vecs[i].code);
            pressed[{vecs[i].row, vecs[i].col}] = 1'b1;
            wait_held(1'b1, "press_held");
            check("press_col_locked", kif.col_n, vecs[i].col_held);
            check("press_key_code", kif.key_code, vecs[i].code);
            pressed = '0;
            wait_held(1'b0, "release_held");
            check("release_next_col", kif.col_n, vecs[i].col_after);
            check("release_code_kept", kif.key_code, vecs[i].code);
        end

        // Bounce on (2,1): low then high falls back to SCAN on the same column.
        goto_col(4'b1101);
        pressed[{2'd2, 2'd1}] = 1'b1;
        next_tick();
        pressed = '0;
        next_tick();
        check("bounce_col_kept", kif.col_n, 4'b1101);
        check("bounce_no_held", {3'b000, kif.key_held}, 4'b0000);
        exp_q.push_back(4'b1001);
        pressed[{2'd2, 2'd1}] = 1'b1;
        next_tick();
        next_tick();
        next_tick();
        check("accept_not_yet", {3'b000, kif.key_valid}, 4'b0000);
        @(posedge clk);
        #1;
        check("accept_valid_pulse", {3'b000, kif.key_valid}, 4'b0001);
        check("accept_held", {3'b000, kif.key_held}, 4'b0001);
        check("accept_code", kif.key_code, 4'b1001);

        // Release with one glitch back low.
        pressed = '0;
        next_tick();
        check("rel_glitch_held_a", {3'b000, kif.key_held}, 4'b0001);
        pressed[{2'd2, 2'd1}] = 1'b1;
        next_tick();
        check("rel_glitch_held_b", {3'b000, kif.key_held}, 4'b0001);
        pressed = '0;
        next_tick();
        next_tick();
        check("rel_held_after_2", {3'b000, kif.key_held}, 4'b0001);
        next_tick();
        check("rel_held_after_3", {3'b000, kif.key_held}, 4'b0000);
        check("rel_col_advanced", kif.col_n, 4'b1011);

        // Two rows on column 2: never accepted until one is released.
        pressed[{2'd0, 2'd2}] = 1'b1;
        pressed[{2'd3, 2'd2}] = 1'b1;
        for (int i = 0; i < 5; i++) next_tick();
        check("multi_col_locked", kif.col_n, 4'b1011);
        check("multi_no_held", {3'b000, kif.key_held}, 4'b0000);
        exp_q.push_back(4'b0010);
        pressed[{2'd3, 2'd2}] = 1'b0;
        wait_held(1'b1, "multi_single_held");
        check("multi_single_code", kif.key_code, 4'b0010);
        check("multi_single_col", kif.col_n, 4'b1011);
        pressed = '0;
        wait_held(1'b0, "multi_release_held");

        // Reset while a key is held, then re-detection of the same key.
        goto_col(4'b1101);
        exp_q.push_back(4'b1001);
        pressed[{2'd2, 2'd1}] = 1'b1;
        wait_held(1'b1, "pre_reset_held");
        #2;
        reset = 1'b1;
        #1;
        check("mid_reset_col_n", kif.col_n, 4'b1110);
        check("mid_reset_key_code", kif.key_code, 4'b0000);
        check("mid_reset_key_held", {3'b000, kif.key_held}, 4'b0000);
        @(negedge clk);
        reset = 1'b0;
        exp_q.push_back(4'b1001);
        wait_held(1'b1, "post_reset_held");
        check("post_reset_code", kif.key_code, 4'b1001);
        pressed = '0;
        wait_held(1'b0, "post_reset_release");

        repeat (4) @(posedge clk);
        #1;
        check("scoreboard_drained", 4'(exp_q.size()), 4'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
